// File: rtl/ser_pkg.sv
// -----------------------------------------------------------------------------
// ser_pkg -- shared definitions for the serial receiver (and future transmitter)
//
// Contents:
//   ser_state_e       receiver frame-sequencing states
//   PARITY_EVEN/ODD   parity-sense constants
//   expected_parity() parity bit a transmitter would append to a word
//
// Configuration macro: SER_RCV_PARITY_EN (adds the PARITY state).
// -----------------------------------------------------------------------------
package ser_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef SER_RCV_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_WAIT_IDLE
  } ser_state_e;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  // Unused upper bits must be zero; they do not disturb the XOR.
  function automatic logic expected_parity(input logic [8:0] data,
                                           input logic       odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/ser_sync.sv
// -----------------------------------------------------------------------------
// ser_sync -- two-flop synchronizer for an asynchronous single-bit input
//
// Parameters:
//   RESET_VAL  value both flops take during reset
// Ports:
//   clk    input   system clock
//   reset  input   synchronous, active-high reset
//   d_i    input   asynchronous input
//   q_o    output  synchronized output (two clocks of latency)
// -----------------------------------------------------------------------------
module ser_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // NOTE: non-blocking assignments let both flops sample their inputs on the
  // same edge, giving a true two-stage chain rather than a single wire.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ser_rcv.sv
// -----------------------------------------------------------------------------
// ser_rcv -- asynchronous serial receiver with a one-word holding register
//
// Frame: start(0), DATA_BITS data LSB first, [parity], stop(1).
// Configuration macro: SER_RCV_PARITY_EN (expect a parity bit before stop).
//
// Parameters: CLK_HZ, BAUD (DIV = CLK_HZ/BAUD clocks per bit), DATA_BITS (5..9),
//             PARITY_ODD (0 even, 1 odd; only meaningful with parity built in)
// Ports:
//   clk        input   system clock
//   reset      input   synchronous, active-high reset
//   serial_in  input   asynchronous serial line, idle high
//   ready      input   consumer accepts the held word this cycle
//   valid      output  a received word is held in data_out
//   data_out   output  received word
//   frame_err  output  held word had stop bit 0
//   parity_err output  held word failed parity (0 without parity)
//   overrun    output  a frame was dropped since the last accept
// -----------------------------------------------------------------------------
module ser_rcv
  import ser_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 2000,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 serial_in,
  input  logic                 ready,
  output logic                 valid,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam int BW  = $clog2(DATA_BITS);

  localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  if (DIV < 4) begin : g_bad_div
    $error("ser_rcv: CLK_HZ/BAUD must be at least 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
    $error("ser_rcv: DATA_BITS must be in 5..9");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_par
    $error("ser_rcv: PARITY_ODD must be 0 or 1");
  end

  logic line_s;

  ser_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (serial_in),
    .q_o   (line_s)
  );

  ser_state_e           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 frm_perr_q, frm_perr_d;
  logic                 done;
  logic                 tick;

  logic                 valid_q, valid_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;
  logic                 ovr_q, ovr_d;

  assign tick = (cnt_q == '0);

  // NOTE: every signal gets its default before the case so no path leaves a
  // combinational output unassigned, which would infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q - CW'(1);
    bit_d      = bit_q;
    shift_d    = shift_q;
    frm_perr_d = frm_perr_q;
    done       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = CNT_HALF;
        if (!line_s) state_d = ST_START;
      end
      ST_START: begin
        if (tick) begin
          // High at mid-start means a glitch: drop it silently.
          if (line_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DATA;
            cnt_d   = CNT_FULL;
            bit_d   = '0;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_d = {line_s, shift_q[DATA_BITS-1:1]};
          cnt_d   = CNT_FULL;
          if (bit_q == BIT_LAST) begin
`ifdef SER_RCV_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
`ifdef SER_RCV_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          frm_perr_d = line_s != expected_parity(9'(shift_q), PARITY_ODD[0]);
          state_d    = ST_STOP;
          cnt_d      = CNT_FULL;
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          done    = 1'b1;
          // A low stop bit may be a break; wait for the line to recover so the
          // long low level is not mistaken for another start bit.
          state_d = line_s ? ST_IDLE : ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (line_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Holding register: an accept frees the slot in the same cycle, so a frame
  // completing alongside an accept is loaded rather than dropped.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ferr_d  = ferr_q;
    perr_d  = perr_q;
    ovr_d   = ovr_q;
    if (valid_q && ready) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (done) begin
      if (!valid_q || ready) begin
        valid_d = 1'b1;
        data_d  = shift_q;
        ferr_d  = ~line_s;
        perr_d  = frm_perr_q;
      end else begin
        ovr_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
      ovr_q      <= 1'b0;
      frm_perr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      perr_q     <= perr_d;
      ovr_q      <= ovr_d;
      frm_perr_q <= frm_perr_d;
    end
  end

  // NOTE: datapath registers carry no reset; the FSM and valid flag guarantee
  // they are written before anything downstream looks at them.
  always_ff @(posedge clk) begin
    cnt_q   <= cnt_d;
    bit_q   <= bit_d;
    shift_q <= shift_d;
    data_q  <= data_d;
  end

  assign valid      = valid_q;
  assign data_out   = data_q;
  assign frame_err  = ferr_q;
`ifdef SER_RCV_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_ser_rcv.sv
// -----------------------------------------------------------------------------
// tb_ser_rcv -- self-checking bench for ser_rcv (DIV = 16).
// Two receivers: DATA_BITS = 8 and DATA_BITS = 5, each on its own line.
// Build with +define+SER_RCV_PARITY_EN to cover the parity variant.
// -----------------------------------------------------------------------------
module tb_ser_rcv;
  import ser_pkg::*;

  localparam int CLK_HZ = 1600;
  localparam int BAUD   = 100;
  localparam int DIV    = 16;
  localparam int POD    = 0;
`ifdef SER_RCV_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  // Drive after posedge p0 -> synchronizer (2) + idle detect (1) + half bit,
  // then one full bit per data/parity/stop bit; valid shows after that edge.
  localparam int LAT8 = 3 + DIV / 2 + DIV * (8 + PAR + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       rx8 = 1'b1, rx5 = 1'b1;
  logic       rdy8 = 1'b1, rdy5 = 1'b1;
  logic       v8, fe8, pe8, ov8;
  logic [7:0] d8;
  logic       v5, fe5, pe5, ov5;
  logic [4:0] d5;

  ser_rcv #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY_ODD(POD)) dut8 (
    .clk(clk), .reset(reset), .serial_in(rx8), .ready(rdy8), .valid(v8),
    .data_out(d8), .frame_err(fe8), .parity_err(pe8), .overrun(ov8)
  );

  ser_rcv #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(5), .PARITY_ODD(POD)) dut5 (
    .clk(clk), .reset(reset), .serial_in(rx5), .ready(rdy5), .valid(v5),
    .data_out(d5), .frame_err(fe5), .parity_err(pe5), .overrun(ov5)
  );

  typedef struct {
    logic [8:0] data;
    logic       fe;
    logic       pe;
    int         cyc;
  } cap_t;

  cap_t cap8[$];
  cap_t cap5[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Every accepted word (valid && ready) is logged once per cycle.
  always @(negedge clk) begin
    if (v8 && rdy8) cap8.push_back('{9'(d8), fe8, pe8, cyc});
    if (v5 && rdy5) cap5.push_back('{9'(d5), fe5, pe5, cyc});
  end

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic set_line(input int sel, input logic v);
    if (sel == 8) rx8 = v;
    else          rx5 = v;
  endtask

  // Drive a level for n clocks; always returns 1 time unit after a posedge.
  task automatic hold(input int sel, input logic v, input int n);
    set_line(sel, v);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // par_mode: -1 correct parity, 0/1 forced parity bit.
  // abort_bit: data bit during which reset is pulsed (-1 for none).
  task automatic send_frame(input int sel, input logic [8:0] data,
                            input int nbits, input int par_mode,
                            input logic stop_bit, input int stop_len,
                            input int abort_bit);
    logic par;
    par = (POD != 0);
    for (int i = 0; i < nbits; i++) par ^= data[i];
    if (par_mode >= 0) par = par_mode[0];
    hold(sel, 1'b0, DIV);
    for (int i = 0; i < nbits; i++) begin
      if (i == abort_bit) begin
        set_line(sel, data[i]);
        repeat (DIV / 2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (DIV / 2 - 2) @(posedge clk);
        #1;
      end else begin
        hold(sel, data[i], DIV);
      end
    end
`ifdef SER_RCV_PARITY_EN
    hold(sel, par, DIV);
`endif
    hold(sel, stop_bit, stop_len);
    hold(sel, 1'b1, 2 * DIV);
  endtask

  typedef struct {
    logic [8:0] data;
    logic       stop;
    int         stop_len;
    logic [7:0] exp_data;
    logic       exp_fe;
  } vec_t;

  vec_t tbl[5];
  int   t0;

  initial begin
    tbl[0] = '{9'h0A5, 1'b1, DIV, 8'hA5, 1'b0};
    tbl[1] = '{9'h000, 1'b1, DIV, 8'h00, 1'b0};
    tbl[2] = '{9'h0FF, 1'b1, DIV, 8'hFF, 1'b0};
    tbl[3] = '{9'h055, 1'b0, 40,  8'h55, 1'b1};  // stop low, break of 40 clocks
    tbl[4] = '{9'h080, 1'b1, DIV, 8'h80, 1'b0};

    // Reset state
    repeat (4) @(posedge clk);
    #1;
    check("rst_valid8", 32'(v8), 0);
    check("rst_ferr8", 32'(fe8), 0);
    check("rst_perr8", 32'(pe8), 0);
    check("rst_ovr8", 32'(ov8), 0);
    check("rst_state8", 32'(dut8.state_q), 32'(ST_IDLE));
    check("rst_valid5", 32'(v5), 0);
    check("rst_ovr5", 32'(ov5), 0);
    reset = 1'b0;
    hold(8, 1'b1, 4);

    // Table-driven frames, ready held high
    for (int i = 0; i < 5; i++) begin
      cap8.delete();
      t0 = cyc;
      send_frame(8, tbl[i].data, 8, -1, tbl[i].stop, tbl[i].stop_len, -1);
      check($sformatf("tbl%0d_count", i), 32'(cap8.size()), 1);
      if (cap8.size() > 0) begin
        check($sformatf("tbl%0d_data", i), 32'(cap8[0].data), 32'(tbl[i].exp_data));
        check($sformatf("tbl%0d_ferr", i), 32'(cap8[0].fe), 32'(tbl[i].exp_fe));
        check($sformatf("tbl%0d_perr", i), 32'(cap8[0].pe), 0);
        if (i == 0) check("latency", 32'(cap8[0].cyc - t0), 32'(LAT8));
      end
      check($sformatf("tbl%0d_valid_drop", i), 32'(v8), 0);
      check($sformatf("tbl%0d_idle", i), 32'(dut8.state_q), 32'(ST_IDLE));
    end

    // Glitch on idle line: 5-clock low pulse
    cap8.delete();
    hold(8, 1'b0, 5);
    hold(8, 1'b1, 3 * DIV);
    check("glitch_count", 32'(cap8.size()), 0);
    check("glitch_state", 32'(dut8.state_q), 32'(ST_IDLE));
    send_frame(8, 9'h03C, 8, -1, 1'b1, DIV, -1);
    check("post_glitch_count", 32'(cap8.size()), 1);
    if (cap8.size() > 0) check("post_glitch_data", 32'(cap8[0].data), 32'h3C);

    // Overrun: two frames while not ready, then accept
    cap8.delete();
    rdy8 = 1'b0;
    send_frame(8, 9'h011, 8, -1, 1'b1, DIV, -1);
    send_frame(8, 9'h022, 8, -1, 1'b1, DIV, -1);
    check("ovr_valid", 32'(v8), 1);
    check("ovr_data", 32'(d8), 32'h11);
    check("ovr_flag", 32'(ov8), 1);
    rdy8 = 1'b1;
    @(posedge clk);
    #1;
    check("ovr_accept_valid", 32'(v8), 0);
    check("ovr_accept_flag", 32'(ov8), 0);
    check("ovr_accept_count", 32'(cap8.size()), 1);
    if (cap8.size() > 0) check("ovr_accept_data", 32'(cap8[0].data), 32'h11);

`ifdef SER_RCV_PARITY_EN
    // 0x07 has three ones: even parity bit must be 1
    cap8.delete();
    send_frame(8, 9'h007, 8, 0, 1'b1, DIV, -1);
    send_frame(8, 9'h007, 8, 1, 1'b1, DIV, -1);
    check("par_count", 32'(cap8.size()), 2);
    if (cap8.size() > 1) begin
      check("par_bad_perr", 32'(cap8[0].pe), 1);
      check("par_bad_data", 32'(cap8[0].data), 32'h07);
      check("par_good_perr", 32'(cap8[1].pe), 0);
      check("par_good_ferr", 32'(cap8[1].fe), 0);
    end
`endif

    // Reset during data bit 4 abandons the frame (8-bit receiver)
    cap8.delete();
    send_frame(8, 9'h0FF, 8, -1, 1'b1, DIV, 4);
    check("rst8_count", 32'(cap8.size()), 0);
    check("rst8_valid", 32'(v8), 0);
    send_frame(8, 9'h081, 8, -1, 1'b1, DIV, -1);
    check("rst8_next_count", 32'(cap8.size()), 1);
    if (cap8.size() > 0) check("rst8_next_data", 32'(cap8[0].data), 32'h81);

    // Same on the 5-bit receiver
    cap5.delete();
    send_frame(5, 9'h01F, 5, -1, 1'b1, DIV, 4);
    check("rst5_count", 32'(cap5.size()), 0);
    send_frame(5, 9'h01F, 5, -1, 1'b1, DIV, -1);
    check("rst5_next_count", 32'(cap5.size()), 1);
    if (cap5.size() > 0) begin
      check("rst5_next_data", 32'(cap5[0].data), 32'h1F);
      check("rst5_next_ferr", 32'(cap5[0].fe), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ser_rcv.md
SER_RCV -- requirements
Module: ser_rcv

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 2000, serial bit rate; DIV = CLK_HZ/BAUD clocks per bit.
REQ-003 SHALL have parameter DATA_BITS, default 8, data bits per frame (legal 5..9).
REQ-004 SHALL have parameter PARITY_ODD, default 0, parity sense when parity is compiled in (0 even, 1 odd).
REQ-005 SHALL have port clk  input  1  system clock; single clock domain.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port serial_in  input  1  asynchronous serial line, idle high.
REQ-008 SHALL have port ready  input  1  consumer accepts the held word this cycle.
REQ-009 SHALL have port valid  output  1  a received word is held in data_out.
REQ-010 SHALL have port data_out  output  DATA_BITS  received word, LSB = first data bit.
REQ-011 SHALL have port frame_err  output  1  held word had stop bit = 0.
REQ-012 SHALL have port parity_err  output  1  held word failed parity (constant 0 without SER_RCV_PARITY_EN).
REQ-013 SHALL have port overrun  output  1  at least one frame dropped since the last accept.

Function
REQ-014 SHALL pass serial_in through a two-flop synchronizer (reset value 1); all sampling uses the synchronized line.
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-016 IDLE: line 0 -> START, counter loaded with DIV/2-1.
REQ-017 START: at counter 0, sample; 1 -> IDLE (glitch rejected, nothing reported); 0 -> DATA, counter DIV-1, bit index 0.
REQ-018 DATA: at counter 0, shift sample in LSB-first, reload DIV-1; after DATA_BITS samples -> PARITY if compiled in, else STOP.
REQ-019 PARITY: at counter 0, sample; mismatch against XOR of data (inverted if PARITY_ODD) flags parity error; -> STOP.
REQ-020 STOP: at counter 0, sample and complete frame; sample 1 -> IDLE; sample 0 -> WAIT_IDLE.
REQ-021 WAIT_IDLE: stay until line is 1, then IDLE (a break never retriggers reception).
REQ-022 On frame completion, valid SHALL rise the next cycle with data_out, frame_err, parity_err loaded together.
REQ-023 Frames with frame or parity error SHALL still be delivered, flagged.
REQ-024 valid, data_out and flags SHALL hold stable until a cycle with valid && ready, after which valid drops unless a new frame loads in the same cycle.
REQ-025 Frame completing while valid && !ready: new frame discarded, held word kept, overrun set.
REQ-026 Frame completing in the same cycle as valid && ready: new frame loaded, overrun not set.
REQ-027 overrun SHALL clear on the accept cycle (valid && ready) and is sticky otherwise.
REQ-028 Counter width SHALL be $clog2(DIV); DIV < 4 or DATA_BITS outside 5..9 SHALL be an elaboration error.

Reset
REQ-029 Reset SHALL force state IDLE, valid 0, frame_err 0, parity_err 0, overrun 0, synchronizer flops 1; data_out value don't-care.
REQ-030 Reset mid-frame SHALL abandon the frame without delivering it; reception restarts on the next falling edge after reset deasserts.

Configuration
REQ-031 Macro SER_RCV_PARITY_EN defined: PARITY state present, one parity bit expected between data and stop.
REQ-032 Macro undefined: no PARITY state, frame is start + DATA_BITS + stop, parity_err tied 0, PARITY_ODD ignored.

Structure
REQ-033 Package ser_pkg SHALL hold the state enum typedef and parity-sense constants, shared with the future transmitter.
REQ-034 Synchronizer SHALL be sub-module ser_sync (two flops, parameterised reset value).

Verification (CLK_HZ=1600, BAUD=100, DIV=16, DATA_BITS=8 unless noted)
REQ-035 Send 0xA5, stop 1, ready=1 -> valid one cycle, data_out=0xA5, flags 0, valid asserted one cycle after stop sample.
REQ-036 Low pulse of 5 clocks on idle line -> no valid, state back to IDLE, next frame 0x3C received correctly.
REQ-037 Send 0x55 with stop=0, line held low 40 clocks -> data_out=0x55, frame_err=1, no second frame during low period.
REQ-038 ready=0, send 0x11 then 0x22 -> data_out stays 0x11, overrun=1; raise ready -> accept 0x11, overrun clears, valid drops.
REQ-039 SER_RCV_PARITY_EN, PARITY_ODD=0, send 0x07 with parity bit 0 -> parity_err=1; with parity bit 1 -> parity_err=0.
REQ-040 Assert reset during bit 4 of 0xFF -> no valid; subsequent frame 0x81 received with DATA_BITS=8, and repeat 0x1F with DATA_BITS=5.
